morse_symbol_decoder: RTL and testbench

MORSE_SYMBOL_DECODER -- requirements
Module: morse_symbol_decoder

---
 rtl/morse_symbol_decoder.sv | 222 ++++++++++++++++++++++
 tb/tb_morse_symbol_decoder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_symbol_decoder.sv
// Morse symbol decoder: samples a keyed line on a divided tick, measures
// mark/space run lengths, classifies dots and dashes, detects letter and
// word gaps, and accumulates the symbols of each letter into a bit vector.
module morse_symbol_decoder #(
  parameter int DIV      = 4,
  parameter int CW       = 4,
  parameter int DOT_MAX  = 2,
  parameter int LGAP_MIN = 3,
  parameter int WGAP_MIN = 7,
  parameter int MAXSYM   = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          serial_inp,
  output logic                          tick,
  output logic                          sym_valid,
  output logic [1:0]                    sym_code,
  output logic                          letter_valid,
  output logic [MAXSYM-1:0]             letter_bits,
  output logic [$clog2(MAXSYM+1)-1:0]   letter_len,
  output logic                          overflow
);

  localparam int LW = $clog2(MAXSYM + 1);
  localparam int DW = $clog2(DIV);

  localparam logic [CW-1:0] RUN_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] RUN_ONE  = CW'(1);
  localparam logic [CW-1:0] RUN_DOT  = CW'(DOT_MAX);
  localparam logic [CW-1:0] RUN_LGAP = CW'(LGAP_MIN);
  localparam logic [CW-1:0] RUN_WGAP = CW'(WGAP_MIN);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_PRE  = DW'(DIV - 2);
  localparam logic [LW-1:0] CNT_FULL = LW'(MAXSYM);

  localparam logic [1:0] CODE_DOT  = 2'b01;
  localparam logic [1:0] CODE_DASH = 2'b10;
  localparam logic [1:0] CODE_LEND = 2'b11;
  localparam logic [1:0] CODE_WEND = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MARK  = 2'd1,
    S_SPACE = 2'd2
  } state_t;

  // Synchronizer and divider
  logic                r_sync1;
  logic                r_sync2;
  logic [DW-1:0]       r_div;
  logic                r_tick;

  // FSM and run-length counter
  state_t              r_state;
  state_t              w_stateNext;
  logic [CW-1:0]       r_run;
  logic [CW-1:0]       w_runNext;
  logic [CW-1:0]       w_runInc;

  // Decisions made on a tick
  logic                w_symEvt;
  logic [1:0]          w_symCode;
  logic                w_appendEvt;
  logic                w_appendBit;
  logic                w_letterEnd;

  // Letter accumulator
  logic [MAXSYM-1:0]   r_acc;
  logic [LW-1:0]       r_cnt;

  // Registered outputs
  logic                r_symValid;
  logic [1:0]          r_symCode;
  logic                r_letterValid;
  logic [MAXSYM-1:0]   r_letterBits;
  logic [LW-1:0]       r_letterLen;
  logic                r_overflow;

  assign w_runInc = (r_run == RUN_MAX) ? RUN_MAX : (r_run + RUN_ONE);

  // Bring the asynchronous keyed line into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= serial_inp;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running divider; tick is registered one count early so it is high
  // exactly while the count sits at its last value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_div  <= (r_div == DIV_LAST) ? '0 : (r_div + DW'(1));
      r_tick <= (r_div == DIV_PRE);
    end
  end

  // FSM state and run length, advanced only on ticks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_run   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_run   <= w_runNext;
    end
  end

  // Next state, next run length and the symbol/letter decisions of a tick
  always_comb begin
    w_stateNext = r_state;
    w_runNext   = r_run;
    w_symEvt    = 1'b0;
    w_symCode   = CODE_WEND;
    w_appendEvt = 1'b0;
    w_appendBit = 1'b0;
    w_letterEnd = 1'b0;
    if (r_tick) begin
      case (r_state)
        S_IDLE: begin
          if (r_sync2) begin
            w_stateNext = S_MARK;
            w_runNext   = RUN_ONE;
          end
        end
        S_MARK: begin
          if (r_sync2) begin
            w_runNext = w_runInc;
          end else begin
            w_symEvt    = 1'b1;
            w_symCode   = (r_run <= RUN_DOT) ? CODE_DOT : CODE_DASH;
            w_appendEvt = 1'b1;
            w_appendBit = (r_run > RUN_DOT);
            w_stateNext = S_SPACE;
            w_runNext   = RUN_ONE;
          end
        end
        S_SPACE: begin
          if (r_sync2) begin
            // A short gap keeps the letter open; a long one was already
            // closed when the run reached the letter-gap length
            w_stateNext = S_MARK;
            w_runNext   = RUN_ONE;
          end else begin
            w_runNext = w_runInc;
            if (w_runInc == RUN_LGAP) begin
              w_symEvt    = 1'b1;
              w_symCode   = CODE_LEND;
              w_letterEnd = 1'b1;
            end
            if (w_runInc == RUN_WGAP) begin
              w_symEvt    = 1'b1;
              w_symCode   = CODE_WEND;
              w_stateNext = S_IDLE;
              w_runNext   = '0;
            end
          end
        end
        default: begin
          w_stateNext = S_IDLE;
          w_runNext   = '0;
        end
      endcase
    end
  end

  // Collect symbols of the current letter; drop extras and flag them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else if (w_letterEnd) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_appendEvt) begin
      if (r_cnt == CNT_FULL) begin
        r_overflow <= 1'b1;
      end else begin
        r_acc <= r_acc | (MAXSYM'(w_appendBit) << r_cnt);
        r_cnt <= r_cnt + LW'(1);
      end
    end
  end

  // Register the pulses and hold the last completed letter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_symValid    <= 1'b0;
      r_symCode     <= 2'b00;
      r_letterValid <= 1'b0;
      r_letterBits  <= '0;
      r_letterLen   <= '0;
    end else begin
      r_symValid    <= w_symEvt;
      r_letterValid <= w_letterEnd;
      if (w_symEvt) begin
        r_symCode <= w_symCode;
      end
      if (w_letterEnd) begin
        r_letterBits <= r_acc;
        r_letterLen  <= r_cnt;
      end
    end
  end

  assign tick         = r_tick;
  assign sym_valid    = r_symValid;
  assign sym_code     = r_symCode;
  assign letter_valid = r_letterValid;
  assign letter_bits  = r_letterBits;
  assign letter_len   = r_letterLen;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// Testbench for morse_symbol_decoder: drives one line level per sample tick
// and compares every pulse against events derived from run lengths.
module tb_morse_symbol_decoder;

  localparam int DIV      = 4;
  localparam int CW       = 4;
  localparam int DOT_MAX  = 2;
  localparam int LGAP_MIN = 3;
  localparam int WGAP_MIN = 7;
  localparam int MAXSYM   = 6;
  localparam int LW       = $clog2(MAXSYM + 1);

  logic              clk;
  logic              rst;
  logic              serial_inp;
  logic              tick;
  logic              sym_valid;
  logic [1:0]        sym_code;
  logic              letter_valid;
  logic [MAXSYM-1:0] letter_bits;
  logic [LW-1:0]     letter_len;
  logic              overflow;

  typedef struct {
    logic [1:0] code;
    int         tickIdx;
  } symExp_t;

  typedef struct {
    logic [MAXSYM-1:0] bits;
    int                len;
    int                tickIdx;
  } letExp_t;

  symExp_t           expSym[$];
  letExp_t           expLet[$];
  bit                lv[$];
  logic              expOvf;
  logic [MAXSYM-1:0] lastBits;
  int                lastLen;

  int numChecks = 0;
  int numPassed = 0;

  int tickCount = 0;
  int cyc = 0;
  int lastTickCyc = 0;
  bit haveTick = 0;
  bit prevSym = 0;
  bit prevLet = 0;

  morse_symbol_decoder #(
    .DIV(DIV), .CW(CW), .DOT_MAX(DOT_MAX), .LGAP_MIN(LGAP_MIN),
    .WGAP_MIN(WGAP_MIN), .MAXSYM(MAXSYM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .serial_inp(serial_inp),
    .tick(tick),
    .sym_valid(sym_valid),
    .sym_code(sym_code),
    .letter_valid(letter_valid),
    .letter_bits(letter_bits),
    .letter_len(letter_len),
    .overflow(overflow)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hang guard
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numChecks++;
    if (observed === expected) begin
      numPassed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Watch tick spacing and every pulse, matching pulses against the
  // expected-event queues in order
  always @(negedge clk) begin
    if (rst) begin
      tickCount = 0;
      haveTick  = 0;
      cyc       = 0;
      prevSym   = 0;
      prevLet   = 0;
    end else begin
      cyc++;
      if (tick) begin
        tickCount++;
        if (haveTick) checkOutput("tickPeriod", cyc - lastTickCyc, DIV);
        haveTick    = 1;
        lastTickCyc = cyc;
      end
      if (sym_valid) begin
        checkOutput("symWidth", 32'(prevSym), 0);
        if (expSym.size() == 0) begin
          checkOutput("symUnexpected", 32'(expSym.size()), 1);
        end else begin
          symExp_t e;
          e = expSym.pop_front();
          checkOutput("symCode", sym_code, e.code);
          checkOutput("symTick", tickCount, e.tickIdx);
        end
      end
      if (letter_valid) begin
        checkOutput("letWidth", 32'(prevLet), 0);
        if (expLet.size() == 0) begin
          checkOutput("letUnexpected", 32'(expLet.size()), 1);
        end else begin
          letExp_t e;
          e = expLet.pop_front();
          checkOutput("letBits", letter_bits, e.bits);
          checkOutput("letLen", letter_len, e.len);
          checkOutput("letTick", tickCount, e.tickIdx);
        end
      end
      prevSym = sym_valid;
      prevLet = letter_valid;
    end
  end

  task automatic addRun(input bit level, input int len);
    for (int k = 0; k < len; k++) lv.push_back(level);
  endtask

  // Derive expected events from the mark/space run lengths of lv.
  // Level lv[i] is seen by the decoder on sample tick i+2, and a decision
  // on that tick shows up while the bench's tick count equals i+2.
  task automatic buildExpected();
    int i;
    int n;
    int s;
    int m;
    int z;
    int sp;
    int accLen;
    logic [MAXSYM-1:0] acc;
    logic [1:0] code;
    i = 0;
    n = lv.size();
    accLen = 0;
    acc = '0;
    while (i < n) begin
      if (lv[i] == 1'b0) begin
        i++;
      end else begin
        s = i;
        while (i < n && lv[i] == 1'b1) i++;
        if (i >= n) break;
        m = i - s;
        code = (m <= DOT_MAX) ? 2'b01 : 2'b10;
        expSym.push_back('{code: code, tickIdx: i + 2});
        if (accLen < MAXSYM) begin
          acc[accLen] = (code == 2'b10);
          accLen++;
        end else begin
          expOvf = 1'b1;
        end
        z = i;
        while (i < n && lv[i] == 1'b0) i++;
        sp = i - z;
        if (sp >= LGAP_MIN) begin
          expSym.push_back('{code: 2'b11, tickIdx: z + LGAP_MIN + 1});
          expLet.push_back('{bits: acc, len: accLen, tickIdx: z + LGAP_MIN + 1});
          lastBits = acc;
          lastLen  = accLen;
          acc = '0;
          accLen = 0;
        end
        if (sp >= WGAP_MIN) begin
          expSym.push_back('{code: 2'b00, tickIdx: z + WGAP_MIN + 1});
        end
      end
    end
  endtask

  task automatic waitTick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 4 * DIV + 4);
    if (!tick) checkOutput("tickTimeout", 32'(tick), 1);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    serial_inp = 1'b0;
    #1;
    checkOutput("rstTick", 32'(tick), 0);
    checkOutput("rstSymValid", 32'(sym_valid), 0);
    checkOutput("rstSymCode", sym_code, 0);
    checkOutput("rstLetValid", 32'(letter_valid), 0);
    checkOutput("rstLetBits", letter_bits, 0);
    checkOutput("rstLetLen", letter_len, 0);
    checkOutput("rstOverflow", 32'(overflow), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    expSym.delete();
    expLet.delete();
    expOvf   = 1'b0;
    lastBits = '0;
    lastLen  = 0;
  endtask

  // Drive one level per sample tick, then let the pipeline drain
  task automatic applyStimulus();
    buildExpected();
    for (int k = 0; k < lv.size(); k++) begin
      waitTick();
      serial_inp = lv[k];
    end
    repeat (4) waitTick();
  endtask

  task automatic finishScenario(input string name);
    checkOutput({name, "_symPending"}, expSym.size(), 0);
    checkOutput({name, "_letPending"}, expLet.size(), 0);
    checkOutput({name, "_overflow"}, 32'(overflow), 32'(expOvf));
    checkOutput({name, "_heldBits"}, letter_bits, lastBits);
    checkOutput({name, "_heldLen"}, letter_len, lastLen);
  endtask

  task automatic genRandom();
    int nSym;
    int m;
    int sp;
    int spaces[8];
    spaces = '{1, 1, 2, 3, 4, 6, 7, 9};
    lv.delete();
    addRun(0, $urandom_range(1, 3));
    nSym = $urandom_range(3, 12);
    for (int k = 0; k < nSym; k++) begin
      m = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 20) : $urandom_range(1, 4);
      addRun(1, m);
      sp = (k == nSym - 1) ? 8 : spaces[$urandom_range(0, 7)];
      addRun(0, sp);
    end
  endtask

  initial begin
    rst = 1'b1;
    serial_inp = 1'b0;

    // Single dot then letter and word gap
    doReset();
    lv.delete(); addRun(0, 1); addRun(1, 2); addRun(0, 8);
    applyStimulus();
    finishScenario("dot");

    // Letter A, dot then dash
    doReset();
    lv.delete(); addRun(0, 2); addRun(1, 1); addRun(0, 1); addRun(1, 3); addRun(0, 8);
    applyStimulus();
    finishScenario("letterA");

    // Seven dots overflow the accumulator
    doReset();
    lv.delete(); addRun(0, 1);
    for (int k = 0; k < 7; k++) begin
      addRun(1, 1);
      addRun(0, (k == 6) ? 8 : 1);
    end
    applyStimulus();
    finishScenario("overflow");

    // Long marks saturate the run counter and stay dashes
    doReset();
    lv.delete(); addRun(0, 1); addRun(1, 20); addRun(0, 2); addRun(1, 16); addRun(0, 8);
    applyStimulus();
    finishScenario("saturate");

    // Reset during the second mark discards the partial letter
    doReset();
    lv.delete(); addRun(0, 1); addRun(1, 1); addRun(0, 1); addRun(1, 2);
    applyStimulus();
    checkOutput("abort_symPending", expSym.size(), 0);
    doReset();
    lv.delete(); addRun(0, 1); addRun(1, 1); addRun(0, 8);
    applyStimulus();
    finishScenario("afterAbort");

    // Randomized letters and gaps
    for (int r = 0; r < 8; r++) begin
      doReset();
      genRandom();
      applyStimulus();
      finishScenario("random");
    end

    $display("[TB] %0d/%0d checks passed", numPassed, numChecks);
    $finish;
  end

endmodule
